// File: rtl/weights_addr_sequencer.sv
// Weights ROM address sequencer: one command yields NB_WEIGHTS addresses per pass, for nb_pass_i passes.
// Optional stall counter output enabled by defining WEIGHTS_ADDR_SEQ_STALL_CNT_EN.
module weights_addr_sequencer #(
    parameter int NB_WEIGHTS = 784,
    parameter int PASS_W     = 16,
    parameter int ADDR_W     = (NB_WEIGHTS > 1) ? $clog2(NB_WEIGHTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rts_i,
    output logic              rtr_o,
    input  logic [PASS_W-1:0] nb_pass_i,
    input  logic              rtr_i,
    output logic              rts_o,
    output logic              sow_o,
    output logic              eow_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              busy_o,
`ifdef WEIGHTS_ADDR_SEQ_STALL_CNT_EN
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NB_WEIGHTS - 1);
    localparam logic              SINGLE = (NB_WEIGHTS == 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [PASS_W-1:0]   r_pass;
    logic [PASS_W-1:0]   r_pass_max;
    logic                r_rtr;
    logic                r_rts;
    logic                r_sow;
    logic                r_eow;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_addr_inc;

    assign w_accept   = rts_i & r_rtr;
    assign w_xfer     = r_rts & rtr_i;
    assign w_addr_inc = r_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_pass     <= '0;
            r_pass_max <= '0;
            r_rtr      <= 1'b1;
            r_rts      <= 1'b0;
            r_sow      <= 1'b0;
            r_eow      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pass_max <= (nb_pass_i == '0) ? '0 : nb_pass_i - PASS_W'(1);
                        r_addr     <= '0;
                        r_pass     <= '0;
                        r_state    <= S_RUN;
                        r_rtr      <= 1'b0;
                        r_rts      <= 1'b1;
                        r_sow      <= 1'b1;
                        r_eow      <= SINGLE;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    // sow/eow are registered alongside the address they describe
                    if (w_xfer) begin
                        if (r_addr != LAST) begin
                            r_addr <= w_addr_inc;
                            r_sow  <= 1'b0;
                            r_eow  <= (w_addr_inc == LAST);
                        end else begin
                            r_addr <= '0;
                            if (r_pass == r_pass_max) begin
                                r_state <= S_DONE;
                                r_rts   <= 1'b0;
                                r_sow   <= 1'b0;
                                r_eow   <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_pass <= r_pass + PASS_W'(1);
                                r_sow  <= 1'b1;
                                r_eow  <= SINGLE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_rtr   <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rts   <= 1'b0;
                    r_rtr   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_sow   <= 1'b0;
                    r_eow   <= 1'b0;
                end
            endcase
        end
    end

`ifdef WEIGHTS_ADDR_SEQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (r_rts && !rtr_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

    assign rtr_o     = r_rtr;
    assign rts_o     = r_rts;
    assign sow_o     = r_sow;
    assign eow_o     = r_eow;
    assign address_o = r_addr;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule

// File: tb/tb_weights_addr_sequencer.sv
// Directed bench for weights_addr_sequencer: one 784-address instance and one single-address instance.
module tb_weights_addr_sequencer;

    localparam int NB_A   = 784;
    localparam int BUDGET = 10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_rts_i = 1'b0, a_rtr_i = 1'b0;
    logic [15:0] a_nb = '0;
    logic        a_rtr_o, a_rts_o, a_sow, a_eow, a_busy, a_done;
    logic [9:0]  a_addr;

    logic        b_rts_i = 1'b0, b_rtr_i = 1'b0;
    logic [15:0] b_nb = '0;
    logic        b_rtr_o, b_rts_o, b_sow, b_eow, b_busy, b_done;
    logic [0:0]  b_addr;

`ifdef WEIGHTS_ADDR_SEQ_STALL_CNT_EN
    logic [31:0] a_stall, b_stall;
`endif

    int checks = 0;
    int errors = 0;

    int n_xfer, n_bad, n_sow, n_eow, n_stab_bad, n_stall, n_rts_cyc, n_done, done_gap, timed_out;

    always #5 clk = ~clk;

    weights_addr_sequencer #(.NB_WEIGHTS(NB_A), .PASS_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .rts_i(a_rts_i), .rtr_o(a_rtr_o), .nb_pass_i(a_nb),
        .rtr_i(a_rtr_i), .rts_o(a_rts_o), .sow_o(a_sow), .eow_o(a_eow), .address_o(a_addr),
        .busy_o(a_busy),
`ifdef WEIGHTS_ADDR_SEQ_STALL_CNT_EN
        .stall_cnt_o(a_stall),
`endif
        .done_o(a_done)
    );

    weights_addr_sequencer #(.NB_WEIGHTS(1), .PASS_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .rts_i(b_rts_i), .rtr_o(b_rtr_o), .nb_pass_i(b_nb),
        .rtr_i(b_rtr_i), .rts_o(b_rts_o), .sow_o(b_sow), .eow_o(b_eow), .address_o(b_addr),
        .busy_o(b_busy),
`ifdef WEIGHTS_ADDR_SEQ_STALL_CNT_EN
        .stall_cnt_o(b_stall),
`endif
        .done_o(b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command to instance A and track every cycle until done_o (or stop_after transfers).
    task automatic a_run(input int np, input bit rnd, input int stop_after);
        int total, exp_addr, last_cyc, done_cyc;
        bit prev_stall;
        logic [9:0] prev_addr;
        logic prev_sow, prev_eow;
        total = NB_A * ((np == 0) ? 1 : np);
        n_xfer = 0; n_bad = 0; n_sow = 0; n_eow = 0; n_stab_bad = 0;
        n_stall = 0; n_rts_cyc = 0; n_done = 0; timed_out = 1;
        exp_addr = 0; last_cyc = -10; done_cyc = -1; prev_stall = 0;
        prev_addr = '0; prev_sow = 1'b0; prev_eow = 1'b0;
        @(negedge clk);
        check("idle_rtr_o", 32'(a_rtr_o), 1);
        a_rts_i = 1'b1; a_nb = 16'(np); a_rtr_i = 1'b1;
        @(negedge clk);
        a_rts_i = 1'b0;
        check("first_addr_latency", 32'({a_rts_o, a_sow, a_addr}), 32'({1'b1, 1'b1, 10'd0}));
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (stop_after >= 0 && n_xfer == stop_after) begin
                timed_out = 0;
                break;
            end
            if (a_done) begin
                n_done++; done_cyc = cyc; timed_out = 0;
                break;
            end
            if (a_rts_o) begin
                n_rts_cyc++;
                if (prev_stall && (a_addr !== prev_addr || a_sow !== prev_sow || a_eow !== prev_eow))
                    n_stab_bad++;
                a_rtr_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (a_rtr_i) begin
                    if (a_addr !== exp_addr[9:0] || a_sow !== (exp_addr == 0) || a_eow !== (exp_addr == NB_A - 1))
                        n_bad++;
                    if (a_sow) n_sow++;
                    if (a_eow) n_eow++;
                    n_xfer++;
                    last_cyc = cyc;
                    exp_addr = (exp_addr == NB_A - 1) ? 0 : exp_addr + 1;
                    prev_stall = 0;
                end else begin
                    n_stall++;
                    prev_stall = 1;
                    prev_addr = a_addr; prev_sow = a_sow; prev_eow = a_eow;
                end
            end else begin
                if (a_sow || a_eow) n_bad++;
                prev_stall = 0;
            end
            @(negedge clk);
        end
        done_gap = done_cyc - last_cyc;
        if (stop_after < 0)
            check("total_expected", 32'(n_xfer), 32'(total));
    endtask

    task automatic a_after_done(input string tag);
        @(negedge clk);
        check({tag, "_idle_flags"}, 32'({a_done, a_busy, a_rtr_o, a_rts_o}), 32'(4'b0010));
    endtask

    initial begin
        int busy_rtr, done_seen;
        // ---- reset state
        rst_n = 1'b0;
        #12;
        check("rst_a_flags", 32'({a_rtr_o, a_rts_o, a_sow, a_eow, a_busy, a_done}), 32'(6'b100000));
        check("rst_a_addr", 32'(a_addr), 0);
        check("rst_b_flags", 32'({b_rtr_o, b_rts_o, b_sow, b_eow, b_busy, b_done}), 32'(6'b100000));
        @(negedge clk);
        rst_n = 1'b1;

        // ---- test 1: single pass, always ready
        a_run(1, 1'b0, -1);
        check("t1_timeout", 32'(timed_out), 0);
        check("t1_xfers", 32'(n_xfer), 784);
        check("t1_seq_bad", 32'(n_bad), 0);
        check("t1_sow", 32'(n_sow), 1);
        check("t1_eow", 32'(n_eow), 1);
        check("t1_done_gap", 32'(done_gap), 1);
        check("t1_no_bubble", 32'(n_rts_cyc), 784);
        a_after_done("t1");

        // ---- test 2: three passes back to back
        a_run(3, 1'b0, -1);
        check("t2_timeout", 32'(timed_out), 0);
        check("t2_xfers", 32'(n_xfer), 2352);
        check("t2_seq_bad", 32'(n_bad), 0);
        check("t2_sow", 32'(n_sow), 3);
        check("t2_eow", 32'(n_eow), 3);
        check("t2_no_bubble", 32'(n_rts_cyc), 2352);
        check("t2_done_gap", 32'(done_gap), 1);
        a_after_done("t2");

        // ---- test 3: nb_pass_i = 0 behaves as one pass
        a_run(0, 1'b0, -1);
        check("t3_timeout", 32'(timed_out), 0);
        check("t3_xfers", 32'(n_xfer), 784);
        check("t3_sow", 32'(n_sow), 1);
        check("t3_eow", 32'(n_eow), 1);
        a_after_done("t3");

        // ---- test 4: random downstream backpressure
        a_run(2, 1'b1, -1);
        check("t4_timeout", 32'(timed_out), 0);
        check("t4_xfers", 32'(n_xfer), 1568);
        check("t4_seq_bad", 32'(n_bad), 0);
        check("t4_stable", 32'(n_stab_bad), 0);
        check("t4_done_gap", 32'(done_gap), 1);
        check("t4_stalls_seen", 32'(n_stall > 0), 1);
`ifdef WEIGHTS_ADDR_SEQ_STALL_CNT_EN
        check("t4_stall_cnt", a_stall, 32'(n_stall));
`endif
        a_after_done("t4");

        // ---- test 5: reset in the middle of the second pass
        a_run(3, 1'b0, 784 + 400);
        check("t5_stop_reached", 32'(timed_out), 0);
        check("t5_addr_before_rst", 32'(a_addr), 400);
        rst_n = 1'b0;
        #1;
        check("t5_rst_flags", 32'({a_rtr_o, a_rts_o, a_sow, a_eow, a_busy, a_done}), 32'(6'b100000));
        check("t5_rst_addr", 32'(a_addr), 0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_done) done_seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (a_done) done_seen++;
        check("t5_no_done", 32'(done_seen), 0);
        a_run(1, 1'b0, -1);
        check("t5_restart_xfers", 32'(n_xfer), 784);
        check("t5_restart_seq_bad", 32'(n_bad), 0);
        a_after_done("t5");

        // ---- test 6: single-address instance, four passes, rts_i held high
        @(negedge clk);
        b_rts_i = 1'b1; b_nb = 16'd4; b_rtr_i = 1'b1;
        n_xfer = 0; n_bad = 0; busy_rtr = 0; done_seen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (b_busy && b_rtr_o) busy_rtr++;
            if (b_done) begin
                done_seen = 1;
                break;
            end
            if (b_rts_o) begin
                n_xfer++;
                if (b_addr !== 1'b0 || b_sow !== 1'b1 || b_eow !== 1'b1) n_bad++;
            end
        end
        check("t6_done_seen", 32'(done_seen), 1);
        check("t6_xfers", 32'(n_xfer), 4);
        check("t6_sow_eow_bad", 32'(n_bad), 0);
        check("t6_busy_rtr", 32'(busy_rtr), 0);
        @(negedge clk);
        check("t6_idle_after_done", 32'({b_busy, b_rtr_o}), 32'(2'b01));
        @(negedge clk);
        check("t6_reaccept_in_idle", 32'({b_busy, b_rts_o}), 32'(2'b11));
        b_rts_i = 1'b0;
        done_seen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (b_done) begin
                done_seen = 1;
                break;
            end
        end
        check("t6_second_done", 32'(done_seen), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
